// File: rtl/read_bus_arbiter.sv
// Round-robin arbiter sharing one AR/R channel pair among four read managers.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module read_bus_arbiter #(
    parameter int MAX_OUTST   = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_rq,
    output logic [3:0]   gnt_rq,
    input  logic [3:0]   m_arvalid,
    output logic [3:0]   m_arready,
    input  logic [15:0]  m_arid,
    input  logic [127:0] m_araddr,
    output logic         s_arvalid,
    input  logic         s_arready,
    output logic [3:0]   s_arid,
    output logic [31:0]  s_araddr,
    input  logic         s_rvalid,
    output logic         s_rready,
    input  logic [3:0]   s_rid,
    input  logic [31:0]  s_rdata,
    input  logic         s_rlast,
    output logic [3:0]   m_rvalid,
    input  logic [3:0]   m_rready,
    output logic [3:0]   m_rid,
    output logic [31:0]  m_rdata,
    output logic         m_rlast,
    output logic [3:0]   outst_cnt,
    output logic         timeout_err,
    output logic         fsm_state
);

    // Handshakes: a beat moves on a channel in a cycle where its valid and ready are both 1.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] OUTST_LIMIT = 4'(MAX_OUTST);
    // A misconfigured instance never grants, which makes the mistake obvious at once.
    localparam bit CFG_OK = (MAX_OUTST >= 1) && (MAX_OUTST <= 15) && (GNT_TIMEOUT >= 1);

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] win, win_n;
    logic [1:0] rr_ptr, rr_n;
    logic [3:0] outst_n;
    logic [1:0] pick, idx;
    logic       pick_vld;
    logic       ar_fire;
    logic       r_done;
    logic       tmo_hit;

    assign fsm_state = state;

    // Round-robin search from rr_ptr+1; the lowest offset is assigned last and wins.
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = rr_ptr + 2'(i);
            if (req_rq[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        s_arvalid = (state == S_GRANT) && m_arvalid[win];
        s_arid    = m_arid[{win, 2'b00} +: 4];
        s_araddr  = m_araddr[{win, 5'b00000} +: 32];
        m_arready = 4'b0000;
        if (state == S_GRANT) begin
            m_arready[win] = s_arready;
        end
    end

    // R channel is routed purely by the manager ID held in rid[3:2].
    always_comb begin
        m_rvalid              = 4'b0000;
        m_rvalid[s_rid[3:2]]  = s_rvalid;
        s_rready              = m_rready[s_rid[3:2]];
        m_rid                 = s_rid;
        m_rdata               = s_rdata;
        m_rlast               = s_rlast;
    end

    assign ar_fire = s_arvalid && s_arready;
    assign r_done  = s_rvalid && s_rready && s_rlast;

    always_comb begin
        outst_n = outst_cnt;
        if (ar_fire && !r_done && outst_cnt != 4'hF) begin
            outst_n = outst_cnt + 4'd1;
        end else if (r_done && !ar_fire && outst_cnt != 4'd0) begin
            outst_n = outst_cnt - 4'd1;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt_rq;
        win_n   = win;
        rr_n    = rr_ptr;
        case (state)
            S_IDLE: begin
                if (CFG_OK && pick_vld && (outst_cnt < OUTST_LIMIT)) begin
                    gnt_n   = 4'b0001 << pick;
                    win_n   = pick;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ar_fire || tmo_hit) begin
                    gnt_n   = 4'b0000;
                    rr_n    = win;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt_rq    <= 4'b0000;
            win       <= 2'd0;
            rr_ptr    <= 2'd3;
            outst_cnt <= 4'd0;
        end else begin
            state     <= state_n;
            gnt_rq    <= gnt_n;
            win       <= win_n;
            rr_ptr    <= rr_n;
            outst_cnt <= outst_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(GNT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic             tmo_err_q;

    // Counts idle grant cycles; fires on the GNT_TIMEOUT-th cycle without arvalid.
    assign tmo_hit = (state == S_GRANT) && !s_arvalid && (tmo_cnt == TMO_LAST);

    always_comb begin
        tmo_n = tmo_cnt;
        if (state == S_IDLE) begin
            tmo_n = '0;
        end else if (!s_arvalid) begin
            tmo_n = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_n;
            tmo_err_q <= tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_bus_arbiter.sv
// Directed self-checking bench for read_bus_arbiter: grant order, outstanding limit,
// R routing, counter boundaries and (with ARB_TIMEOUT_EN) grant timeout.
module tb_read_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_rq;
    logic [3:0]   gnt_rq;
    logic [3:0]   m_arvalid;
    logic [3:0]   m_arready;
    logic [15:0]  m_arid;
    logic [127:0] m_araddr;
    logic         s_arvalid;
    logic         s_arready;
    logic [3:0]   s_arid;
    logic [31:0]  s_araddr;
    logic         s_rvalid;
    logic         s_rready;
    logic [3:0]   s_rid;
    logic [31:0]  s_rdata;
    logic         s_rlast;
    logic [3:0]   m_rvalid;
    logic [3:0]   m_rready;
    logic [3:0]   m_rid;
    logic [31:0]  m_rdata;
    logic         m_rlast;
    logic [3:0]   outst_cnt;
    logic         timeout_err;
    logic         fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    read_bus_arbiter #(.MAX_OUTST(4), .GNT_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_rq(req_rq), .gnt_rq(gnt_rq),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rlast(s_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rlast(m_rlast),
        .outst_cnt(outst_cnt), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req_rq    = 4'b0000;
        m_arvalid = 4'b0000;
        m_arid    = 16'h0000;
        m_araddr  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rid     = 4'b0000;
        s_rdata   = 32'h0;
        s_rlast   = 1'b0;
        m_rready  = 4'b0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ar_fields();
        for (int i = 0; i < 4; i++) begin
            m_araddr[32*i +: 32] = 32'hA000_0000 + 32'(i);
            m_arid[4*i +: 4]     = {2'(i), 2'b01};
        end
    endtask

    // Waits (bounded) until some grant is visible; the caller checks which one.
    task automatic wait_gnt();
        for (int i = 0; i < 8; i++) begin
            if (gnt_rq !== 4'b0000) break;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst       = 1'b1;
        req_rq    = 4'b1111;
        m_arvalid = 4'b1111;
        s_arready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_rq); end
        n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_outst: got %0d want 0", outst_cnt); end
        n_cmp++; if (fsm_state !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", fsm_state); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        n_cmp++; if (s_arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_sarvalid: got %b want 0", s_arvalid); end
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        m_araddr[31:0] = 32'h1000_0040;
        m_arid[3:0]    = 4'h3;
        req_rq    = 4'b0001;
        m_arvalid = 4'b0001;
        s_arready = 1'b1;
        #1;
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL single_early: got %b want 0000", gnt_rq); end
        @(negedge clk);
        n_cmp++; if (gnt_rq !== 4'b0001) begin n_bad++; $display("FAIL single_gnt: got %b want 0001", gnt_rq); end
        n_cmp++; if (s_araddr !== 32'h1000_0040) begin n_bad++; $display("FAIL single_addr: got %h want 10000040", s_araddr); end
        n_cmp++; if (s_arid !== 4'h3) begin n_bad++; $display("FAIL single_arid: got %h want 3", s_arid); end
        n_cmp++; if (m_arready !== 4'b0001) begin n_bad++; $display("FAIL single_arready: got %b want 0001", m_arready); end
        req_rq = 4'b0000;
        @(negedge clk);
        m_arvalid = 4'b0000;
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL single_release: got %b want 0000", gnt_rq); end
        n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL single_outst: got %0d want 1", outst_cnt); end
        s_rvalid = 1'b1; s_rid = 4'b0000; s_rlast = 1'b1; m_rready = 4'b0001;
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL single_drain: got %0d want 0", outst_cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        do_reset();
        set_ar_fields();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_rq    = 4'b1111;
        m_arvalid = 4'b1111;
        s_arready = 1'b1;
        m_rready  = 4'b1111;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_gnt();
            n_cmp++; if (gnt_rq !== (4'b0001 << e)) begin n_bad++; $display("FAIL rr_gnt: got %b want %b", gnt_rq, 4'b0001 << e); end
            n_cmp++; if (s_araddr !== 32'hA000_0000 + 32'(e)) begin n_bad++; $display("FAIL rr_addr: got %h want %h", s_araddr, 32'hA000_0000 + 32'(e)); end
            @(negedge clk);
            n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL rr_outst: got %0d want 1", outst_cnt); end
            s_rvalid = 1'b1; s_rid = {e, 2'b01}; s_rlast = 1'b1;
            @(negedge clk);
            s_rvalid = 1'b0; s_rlast = 1'b0;
            n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL rr_drain: got %0d want 0", outst_cnt); end
        end
        req_rq = 4'b0000;
    endtask

    task automatic test_outst_limit();
        do_reset();
        set_ar_fields();
        req_rq    = 4'b1111;
        m_arvalid = 4'b1111;
        s_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt();
            n_cmp++; if (gnt_rq !== (4'b0001 << k)) begin n_bad++; $display("FAIL lim_gnt%0d: got %b want %b", k, gnt_rq, 4'b0001 << k); end
            @(negedge clk);
        end
        n_cmp++; if (outst_cnt !== 4'd4) begin n_bad++; $display("FAIL lim_outst: got %0d want 4", outst_cnt); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL lim_blocked: got %b want 0000", gnt_rq); end
        end
        s_rvalid = 1'b1; s_rid = 4'b1000; s_rlast = 1'b1; m_rready = 4'b0100;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0100) begin n_bad++; $display("FAIL lim_rvalid: got %b want 0100", m_rvalid); end
        n_cmp++; if (s_rready !== 1'b1) begin n_bad++; $display("FAIL lim_rready: got %b want 1", s_rready); end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        n_cmp++; if (outst_cnt !== 4'd3) begin n_bad++; $display("FAIL lim_dec: got %0d want 3", outst_cnt); end
        @(negedge clk);
        n_cmp++; if (gnt_rq !== 4'b0001) begin n_bad++; $display("FAIL lim_resume: got %b want 0001", gnt_rq); end
        req_rq = 4'b0000;
    endtask

    task automatic test_r_routing();
        do_reset();
        s_rvalid = 1'b1; s_rid = 4'b0110; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b0;
        m_rready = 4'b0010;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0010) begin n_bad++; $display("FAIL rt_rvalid1: got %b want 0010", m_rvalid); end
        n_cmp++; if (s_rready !== 1'b1) begin n_bad++; $display("FAIL rt_rready1: got %b want 1", s_rready); end
        n_cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rt_rdata: got %h want deadbeef", m_rdata); end
        n_cmp++; if (m_rid !== 4'b0110) begin n_bad++; $display("FAIL rt_rid: got %b want 0110", m_rid); end
        @(negedge clk);
        s_rid = 4'b1100;
        #1;
        n_cmp++; if (m_rvalid !== 4'b1000) begin n_bad++; $display("FAIL rt_rvalid2: got %b want 1000", m_rvalid); end
        n_cmp++; if (s_rready !== 1'b0) begin n_bad++; $display("FAIL rt_rready2: got %b want 0", s_rready); end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0000) begin n_bad++; $display("FAIL rt_idle: got %b want 0000", m_rvalid); end
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_ar_fields();
        req_rq    = 4'b0011;
        m_arvalid = 4'b0011;
        s_arready = 1'b1;
        wait_gnt();
        @(negedge clk);
        wait_gnt();
        @(negedge clk);
        n_cmp++; if (outst_cnt !== 4'd2) begin n_bad++; $display("FAIL same_pre: got %0d want 2", outst_cnt); end
        wait_gnt();
        n_cmp++; if (gnt_rq !== 4'b0001) begin n_bad++; $display("FAIL same_gnt: got %b want 0001", gnt_rq); end
        s_rvalid = 1'b1; s_rid = 4'b0000; s_rlast = 1'b1; m_rready = 4'b0001;
        req_rq = 4'b0000;
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        n_cmp++; if (outst_cnt !== 4'd2) begin n_bad++; $display("FAIL same_cnt: got %0d want 2", outst_cnt); end
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL same_release: got %b want 0000", gnt_rq); end
    endtask

    task automatic test_hold_grant();
        do_reset();
        set_ar_fields();
        req_rq    = 4'b0100;
        s_arready = 1'b1;
        wait_gnt();
        n_cmp++; if (gnt_rq !== 4'b0100) begin n_bad++; $display("FAIL hold_gnt: got %b want 0100", gnt_rq); end
        req_rq = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (gnt_rq !== 4'b0100) begin n_bad++; $display("FAIL hold_kept%0d: got %b want 0100", k, gnt_rq); end
            n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL hold_tmo%0d: got %b want 0", k, timeout_err); end
        end
        n_cmp++; if (s_arvalid !== 1'b0) begin n_bad++; $display("FAIL hold_sarvalid: got %b want 0", s_arvalid); end
        n_cmp++; if (m_arready !== 4'b0100) begin n_bad++; $display("FAIL hold_arready: got %b want 0100", m_arready); end
        n_cmp++; if (s_araddr !== 32'hA000_0002) begin n_bad++; $display("FAIL hold_addr: got %h want a0000002", s_araddr); end
        m_arvalid = 4'b0100;
        @(negedge clk);
        m_arvalid = 4'b0000;
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL hold_done: got %b want 0000", gnt_rq); end
        n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL hold_outst: got %0d want 1", outst_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_rq    = 4'b0001;
        m_arvalid = 4'b0001;
        s_arready = 1'b1;
        wait_gnt();
        req_rq = 4'b0000;
        @(negedge clk);
        m_arvalid = 4'b0000;
        n_cmp++; if (outst_cnt !== 4'd1) begin n_bad++; $display("FAIL mid_pre: got %0d want 1", outst_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL mid_async: got %0d want 0", outst_cnt); end
        @(negedge clk);
        rst = 1'b0;
        s_rvalid = 1'b1; s_rid = 4'b0000; s_rlast = 1'b1; m_rready = 4'b0001;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0001) begin n_bad++; $display("FAIL mid_route: got %b want 0001", m_rvalid); end
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL mid_underflow: got %0d want 0", outst_cnt); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_rq    = 4'b0100;
        s_arready = 1'b1;
        wait_gnt();
        n_cmp++; if (gnt_rq !== 4'b0100) begin n_bad++; $display("FAIL tmo_gnt: got %b want 0100", gnt_rq); end
        req_rq = 4'b1100;
        repeat (15) @(negedge clk);
        n_cmp++; if (gnt_rq !== 4'b0100) begin n_bad++; $display("FAIL tmo_early: got %b want 0100", gnt_rq); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early_err: got %b want 0", timeout_err); end
        @(negedge clk);
        n_cmp++; if (gnt_rq !== 4'b0000) begin n_bad++; $display("FAIL tmo_drop: got %b want 0000", gnt_rq); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_pulse: got %b want 1", timeout_err); end
        @(negedge clk);
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse_end: got %b want 0", timeout_err); end
        n_cmp++; if (gnt_rq !== 4'b1000) begin n_bad++; $display("FAIL tmo_next: got %b want 1000", gnt_rq); end
        n_cmp++; if (outst_cnt !== 4'd0) begin n_bad++; $display("FAIL tmo_outst: got %0d want 0", outst_cnt); end
        req_rq = 4'b0000;
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_outst_limit();
        test_r_routing();
        test_same_cycle();
        test_hold_grant();
        test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
